nco_mixer_dec: RTL and testbench

- Downstream consumer of the SPI configuration block's `phase_inc` word. Converts a 1-bit RF comparator sample stream to decimated baseband I/Q.
- A 20-bit phase accumulator generates square-wave quadrature LOs. Each LO is XOR-mixed with the RF bit.
- Mixed bits are integrated and dumped once per frame of 2^DEC_LOG2 samples.
- Output feeds the AM envelope/gain stage.

---
 rtl/nco_mixer_dec.sv | 135 +++++++++++++
 tb/tb_nco_mixer_dec.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nco_mixer_dec.sv
// rtl/nco_mixer_dec.sv - square-wave NCO, 1-bit quadrature mixer and integrate-and-dump decimator
module nco_mixer_dec #(
    parameter int PHASE_W  = 20,
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = DEC_LOG2 + 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RF_IN,
    input  logic [PHASE_W-1:0]      PHASE_INC,
    output logic signed [OUT_W-1:0] I_OUT,
    output logic signed [OUT_W-1:0] Q_OUT,
    output logic                    OUT_VALID
);

    localparam logic [DEC_LOG2-1:0] TERM = '1;

    typedef enum logic {PRIME, RUN} state_t;

    state_t                    state;
    logic                      cap_valid;
    logic                      mix_valid;

    logic [PHASE_W-1:0]        acc;
    logic [PHASE_W-1:0]        pinc_reg;
    logic [DEC_LOG2-1:0]       cap_cnt;
    logic                      rf_c;
    logic                      i_neg_c;
    logic                      q_neg_c;

    logic                      mix_i;
    logic                      mix_q;

    logic [DEC_LOG2-1:0]       frame_cnt;
    logic signed [OUT_W-1:0]   int_i;
    logic signed [OUT_W-1:0]   int_q;
    logic signed [OUT_W-1:0]   d_i;
    logic signed [OUT_W-1:0]   d_q;

    // Capture stage: latch the RF bit with the LO signs of the current phase, then advance the NCO.
    // The tuning word is reloaded only with the last sample of a frame so a frame never mixes two words.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc      <= '0;
            pinc_reg <= PHASE_INC;
            cap_cnt  <= '0;
            rf_c     <= 1'b0;
            i_neg_c  <= 1'b0;
            q_neg_c  <= 1'b0;
        end else begin
            rf_c     <= RF_IN;
            i_neg_c  <= acc[PHASE_W-1] ^ acc[PHASE_W-2];
            q_neg_c  <= acc[PHASE_W-1];
            acc      <= acc + pinc_reg;
            cap_cnt  <= cap_cnt + DEC_LOG2'(1);
            if (cap_cnt == TERM) begin
                pinc_reg <= PHASE_INC;
            end
        end
    end

    // Start-up sequencer: fills capture then mix stage before the integrators are allowed to run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= PRIME;
            cap_valid <= 1'b0;
            mix_valid <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    if (!cap_valid) begin
                        cap_valid <= 1'b1;
                    end else begin
                        mix_valid <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    cap_valid <= 1'b1;
                    mix_valid <= 1'b1;
                end
                default: begin
                    state     <= PRIME;
                    cap_valid <= 1'b0;
                    mix_valid <= 1'b0;
                end
            endcase
        end
    end

    // Mix stage: XOR of the RF bit with each LO sign; 1 means a +1 product.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mix_i <= 1'b0;
            mix_q <= 1'b0;
        end else begin
            mix_i <= rf_c ^ i_neg_c;
            mix_q <= rf_c ^ q_neg_c;
        end
    end

    // Map each mixed bit to a signed +1/-1 step.
    always_comb begin
        d_i = mix_i ? OUT_W'(1) : {OUT_W{1'b1}};
        d_q = mix_q ? OUT_W'(1) : {OUT_W{1'b1}};
    end

    // Integrate-and-dump: the final sample goes straight into the output and the integrators restart at zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            int_i     <= '0;
            int_q     <= '0;
            frame_cnt <= '0;
            I_OUT     <= '0;
            Q_OUT     <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (mix_valid) begin
                frame_cnt <= frame_cnt + DEC_LOG2'(1);
                if (frame_cnt == TERM) begin
                    I_OUT     <= int_i + d_i;
                    Q_OUT     <= int_q + d_q;
                    OUT_VALID <= 1'b1;
                    int_i     <= '0;
                    int_q     <= '0;
                end else begin
                    int_i     <= int_i + d_i;
                    int_q     <= int_q + d_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_mixer_dec.sv
// tb/tb_nco_mixer_dec.sv - self-checking bench for nco_mixer_dec
module tb_nco_mixer_dec;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              RF_IN = 1'b0;
    logic [19:0]       PHASE_INC = '0;
    logic signed [7:0] I_OUT;
    logic signed [7:0] Q_OUT;
    logic              OUT_VALID;

    nco_mixer_dec dut (
        .CLK       (CLK),
        .RST       (RST),
        .RF_IN     (RF_IN),
        .PHASE_INC (PHASE_INC),
        .I_OUT     (I_OUT),
        .Q_OUT     (Q_OUT),
        .OUT_VALID (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          edge_n;
    logic [19:0] m_acc;
    logic [19:0] m_pinc;
    int          m_si;
    int          m_sq;
    int          due_q[$];
    int          ival_q[$];
    int          qval_q[$];
    int          exp_i;
    int          exp_q;

    // observed strobes
    int strobe_cnt;
    int first_strobe;
    int str_i[16];
    int str_q[16];
    int str_e[16];

    typedef struct {
        logic [3:0]  pat;
        logic [19:0] pinc;
        int          exp_i;
        int          exp_q;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic do_reset(input logic [19:0] pinc, input int n);
        RST = 1'b1;
        PHASE_INC = pinc;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        m_acc  = '0;
        m_pinc = pinc;
        m_si   = 0;
        m_sq   = 0;
        due_q.delete();
        ival_q.delete();
        qval_q.delete();
        exp_i = 0;
        exp_q = 0;
        strobe_cnt   = 0;
        first_strobe = -1;
        edge_n       = 0;
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_i_out", int'(I_OUT), 0);
        check("rst_q_out", int'(Q_OUT), 0);
        RST = 1'b0;
    endtask

    task automatic tick(input logic rf);
        int  s;
        logic in_neg;
        logic qn_neg;
        logic ev;
        RF_IN = rf;
        @(posedge CLK);
        edge_n++;
        s      = edge_n - 1;
        in_neg = m_acc[19] ^ m_acc[18];
        qn_neg = m_acc[19];
        m_si  += (rf ^ in_neg) ? 1 : -1;
        m_sq  += (rf ^ qn_neg) ? 1 : -1;
        m_acc  = m_acc + m_pinc;
        if ((s % 64) == 63) begin
            m_pinc = PHASE_INC;
            due_q.push_back(edge_n + 2);
            ival_q.push_back(m_si);
            qval_q.push_back(m_sq);
            m_si = 0;
            m_sq = 0;
        end
        @(negedge CLK);
        ev = 1'b0;
        if (due_q.size() > 0 && due_q[0] == edge_n) begin
            ev = 1'b1;
            void'(due_q.pop_front());
            exp_i = ival_q.pop_front();
            exp_q = qval_q.pop_front();
        end
        check("model_out_valid", int'(OUT_VALID), int'(ev));
        check("model_i_out", int'(I_OUT), exp_i);
        check("model_q_out", int'(Q_OUT), exp_q);
        if (OUT_VALID) begin
            if (strobe_cnt == 0) first_strobe = edge_n;
            if (strobe_cnt < 16) begin
                str_i[strobe_cnt] = int'(I_OUT);
                str_q[strobe_cnt] = int'(Q_OUT);
                str_e[strobe_cnt] = edge_n;
            end
            strobe_cnt++;
        end
    endtask

    initial begin
        // pattern bit k is the RF bit for samples with index k mod 4
        vecs[0] = '{pat: 4'b1111, pinc: 20'h00000, exp_i:  64, exp_q:  64};
        vecs[1] = '{pat: 4'b0000, pinc: 20'h00000, exp_i: -64, exp_q: -64};
        vecs[2] = '{pat: 4'b1001, pinc: 20'h40000, exp_i:  64, exp_q:   0};
        vecs[3] = '{pat: 4'b0011, pinc: 20'h40000, exp_i:   0, exp_q:  64};

        // table-driven frames: constant word, periodic RF pattern, three frames each
        for (int v = 0; v < 4; v++) begin
            do_reset(vecs[v].pinc, 3);
            for (int s = 0; s < 64 * 3 + 4; s++) begin
                tick(vecs[v].pat[s % 4]);
            end
            check("vec_first_strobe", first_strobe, 66);
            check("vec_strobe_count", strobe_cnt, 3);
            for (int k = 0; k < 3; k++) begin
                check("vec_strobe_edge", str_e[k], 66 + 64 * k);
                check("vec_i", str_i[k], vecs[v].exp_i);
                check("vec_q", str_q[k], vecs[v].exp_q);
            end
        end

        // tuning word change mid-frame only takes effect from the next frame
        do_reset(20'h00000, 2);
        for (int s = 0; s < 140; s++) begin
            if (s == 20) PHASE_INC = 20'h80000;
            tick(1'b1);
        end
        check("tune_strobe_count", strobe_cnt, 2);
        check("tune_f0_i", str_i[0], 64);
        check("tune_f0_q", str_q[0], 64);
        check("tune_f1_edge", str_e[1], 130);
        check("tune_f1_i", str_i[1], 0);
        check("tune_f1_q", str_q[1], 0);

        // one-cycle reset at sample 40 of frame 1 discards the partial frame
        do_reset(20'h00000, 2);
        for (int s = 0; s < 104; s++) tick(1'b1);
        check("mid_pre_strobes", strobe_cnt, 1);
        do_reset(20'h00000, 1);
        for (int s = 0; s < 70; s++) tick(1'b1);
        check("mid_first_strobe", first_strobe, 66);
        check("mid_strobe_count", strobe_cnt, 1);
        check("mid_i", str_i[0], 64);
        check("mid_q", str_q[0], 64);

        // random RF stream with random retuning, including large words that wrap the accumulator
        do_reset(20'(32'hFFFF7), 2);
        for (int s = 0; s < 10000; s++) begin
            if ($urandom_range(0, 49) == 0) PHASE_INC = 20'($urandom);
            tick(1'($urandom_range(0, 1)));
        end
        check("rand_strobe_count", strobe_cnt, 156);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
